// File: rtl/usb_asp_spi_pkg.sv
// -----------------------------------------------------------------------------
// usb_asp_spi_pkg
// Shared definitions for the USB ASP SPI flash-emulating responder:
// opcode constants, FSM state encoding, idle fill byte and the power-up
// memory pattern helper.
// -----------------------------------------------------------------------------
package usb_asp_spi_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PROG = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  localparam logic [7:0] IDLE_FILL    = 8'hFF;
  localparam logic [7:0] MEM_INIT_XOR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_ID,
    ST_STATUS,
    ST_IGNORE
  } state_e;

  // Contents of a memory byte that has never been written.
  function automatic logic [7:0] mem_init_byte(input logic [7:0] a);
    return a ^ MEM_INIT_XOR;
  endfunction

endpackage

// File: rtl/usb_asp_spi_responder_shifter.sv
// -----------------------------------------------------------------------------
// spi_target_shifter
// Oversamples the mode-3 SPI pins in the clk domain, detects edges and runs
// the receive/transmit shift registers and the 3-bit bit counter.
//
// Ports:
//   clk_i, reset_i          system clock, async active-high reset
//   spi_clk_i/csn_i/mosi_i  raw SPI pins from the master
//   tx_byte_i               next response byte, sampled when load_req_o is high
//   spi_miso_o              target-out data (tx_sh[7])
//   busy_o                  synchronized chip select is low
//   byte_done_o, rx_byte_o  one-cycle pulse with the completed received byte
//   load_req_o              falling edge at a byte boundary (tx_byte_i loaded)
//   cs_start_o, cs_end_o    synchronized chip-select fall / rise pulses
// -----------------------------------------------------------------------------
module spi_target_shifter
  import usb_asp_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  input  logic [7:0] tx_byte_i,
  output logic       spi_miso_o,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o,
  output logic       load_req_o,
  output logic       cs_start_o,
  output logic       cs_end_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, csn_dly_q;
  logic [7:0]             rx_sh_q, rx_sh_d;
  logic [7:0]             tx_sh_q, tx_sh_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   sclk_s, csn_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_dly_q;
  assign sclk_fall  = ~sclk_s & sclk_dly_q;
  assign cs_start_o = ~csn_s & csn_dly_q;
  assign cs_end_o   = csn_s & ~csn_dly_q;

  // busy drops in the same cycle a CS rise is detected, so a coincident
  // clock edge is ignored and chip select wins.
  assign busy_o      = ~csn_s;
  assign rx_byte_o   = {rx_sh_q[6:0], mosi_s};
  assign byte_done_o = busy_o & sclk_rise & (bit_cnt_q == 3'd7);
  assign load_req_o  = busy_o & sclk_fall & (bit_cnt_q == 3'd0);
  assign spi_miso_o  = tx_sh_q[7];

  always_comb begin
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    bit_cnt_d = bit_cnt_q;
    if (cs_end_o) begin
      rx_sh_d   = '0;
      tx_sh_d   = IDLE_FILL;
      bit_cnt_d = '0;
    end else if (cs_start_o) begin
      tx_sh_d   = IDLE_FILL;
      bit_cnt_d = '0;
    end else if (busy_o && sclk_rise) begin
      rx_sh_d   = rx_byte_o;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else if (busy_o && sclk_fall) begin
      tx_sh_d = (bit_cnt_q == 3'd0) ? tx_byte_i : {tx_sh_q[6:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      mosi_sync_q <= '1;
      sclk_dly_q  <= 1'b1;
      csn_dly_q   <= 1'b1;
      rx_sh_q     <= '0;
      tx_sh_q     <= IDLE_FILL;
      bit_cnt_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_dly_q  <= sclk_s;
      csn_dly_q   <= csn_s;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/usb_asp_spi_responder.sv
// -----------------------------------------------------------------------------
// usb_asp_spi_responder
// Minimal serial-flash emulating SPI target (mode 3) used as the far end of
// the USB ASP SPI master. Decodes READ/PROG/RDID/RDSR/WREN/WRDI and serves a
// small byte memory whose unwritten bytes read as addr ^ 8'hA5.
//
// Build option: define USB_ASP_SPI_RESP_PROGRAM_EN to implement PROG, WREN
// and WRDI. Without it those opcodes are counted but ignored, wel is 0 and
// the memory is a read-only pattern.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   spi_clk/csn/mosi  SPI pins from the master
//   spi_miso          target-out data (1 when idle)
//   busy              synchronized chip select is low
//   wel               write-enable latch
//   cmd_count         decoded opcode count, wraps
// -----------------------------------------------------------------------------
module usb_asp_spi_responder
  import usb_asp_spi_pkg::*;
#(
  parameter int          MEM_AW      = 6,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       busy,
  output logic       wel,
  output logic [7:0] cmd_count
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        addr_cnt_q, addr_cnt_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [7:0]        cmd_count_q, cmd_count_d;
  logic              byte_done, load_req, cs_start, cs_end;
  logic [7:0]        rx_byte, tx_byte, mem_rd;

  spi_target_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk_i       (clk),
    .reset_i     (reset),
    .spi_clk_i   (spi_clk),
    .spi_csn_i   (spi_csn),
    .spi_mosi_i  (spi_mosi),
    .tx_byte_i   (tx_byte),
    .spi_miso_o  (spi_miso),
    .busy_o      (busy),
    .byte_done_o (byte_done),
    .rx_byte_o   (rx_byte),
    .load_req_o  (load_req),
    .cs_start_o  (cs_start),
    .cs_end_o    (cs_end)
  );

`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
  logic                 wel_q, wel_d, wrote_q, wrote_d, is_wr_q, is_wr_d, mem_we;
  logic [7:0]           mem_q [2**MEM_AW];
  logic [2**MEM_AW-1:0] written_q;

  // A per-byte written flag stands in for memory initialisation: bytes never
  // written return the power-up pattern, so the array itself needs no reset.
  assign mem_rd = written_q[addr_q] ? mem_q[addr_q] : mem_init_byte(8'(addr_q));
  assign wel    = wel_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
      wel_q     <= 1'b0;
      wrote_q   <= 1'b0;
      is_wr_q   <= 1'b0;
    end else begin
      if (mem_we) written_q[addr_q] <= 1'b1;
      wel_q   <= wel_d;
      wrote_q <= wrote_d;
      is_wr_q <= is_wr_d;
    end
  end
`else
  assign mem_rd = mem_init_byte(8'(addr_q));
  assign wel    = 1'b0;
`endif

  assign cmd_count = cmd_count_q;

  always_comb begin
    tx_byte = IDLE_FILL;
    case (state_q)
      ST_RD:     tx_byte = mem_rd;
      ST_STATUS: tx_byte = {6'b0, wel, 1'b0};
      ST_ID: begin
        case (id_idx_q)
          2'd0:    tx_byte = JEDEC_ID[23:16];
          2'd1:    tx_byte = JEDEC_ID[15:8];
          2'd2:    tx_byte = JEDEC_ID[7:0];
          default: tx_byte = IDLE_FILL;
        endcase
      end
      default:   tx_byte = IDLE_FILL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_cnt_d  = addr_cnt_q;
    id_idx_d    = id_idx_q;
    cmd_count_d = cmd_count_q;
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
    wel_d   = wel_q;
    wrote_d = wrote_q;
    is_wr_d = is_wr_q;
    mem_we  = 1'b0;
`endif
    if (cs_end) begin
      state_d = ST_IDLE;
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
      if (wrote_q) wel_d = 1'b0;
      wrote_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (cs_start) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            cmd_count_d = cmd_count_q + 8'd1;
            addr_cnt_d  = '0;
            id_idx_d    = '0;
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
            is_wr_d = (rx_byte == OP_PROG);
`endif
            case (rx_byte)
              OP_READ: state_d = ST_ADDR;
              OP_RDID: state_d = ST_ID;
              OP_RDSR: state_d = ST_STATUS;
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
              OP_PROG: state_d = ST_ADDR;
              OP_WREN: begin
                wel_d   = 1'b1;
                state_d = ST_IGNORE;
              end
              OP_WRDI: begin
                wel_d   = 1'b0;
                state_d = ST_IGNORE;
              end
`endif
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            // Big-endian shift; only the low MEM_AW bits survive.
            addr_d     = MEM_AW'({addr_q, rx_byte});
            addr_cnt_d = addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd2) begin
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
              state_d = is_wr_q ? ST_WR : ST_RD;
`else
              state_d = ST_RD;
`endif
            end
          end
        end
        ST_RD: if (load_req) addr_d = addr_q + MEM_AW'(1);
        ST_ID: if (load_req && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
        ST_WR: begin
          if (byte_done) begin
            if (wel_q) begin
              mem_we  = 1'b1;
              wrote_d = 1'b1;
            end
            addr_d = addr_q + MEM_AW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      id_idx_q    <= '0;
      cmd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      id_idx_q    <= id_idx_d;
      cmd_count_q <= cmd_count_d;
    end
  end

endmodule

// File: tb/tb_usb_asp_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_usb_asp_spi_responder
// Directed bench for usb_asp_spi_responder acting as a mode-3 SPI master.
// Expected bytes are hand-computed; builds with or without
// USB_ASP_SPI_RESP_PROGRAM_EN select the matching program-path expectations.
// -----------------------------------------------------------------------------
module tb_usb_asp_spi_responder;

  localparam int HALF = 8;  // clk cycles per SPI clock phase

`ifdef USB_ASP_SPI_RESP_PROGRAM_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk, spi_csn, spi_mosi;
  logic       spi_miso, busy, wel;
  logic [7:0] cmd_count;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  usb_asp_spi_responder #(
    .MEM_AW      (6),
    .JEDEC_ID    (24'hEF4016),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .spi_csn   (spi_csn),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .busy      (busy),
    .wel       (wel),
    .cmd_count (cmd_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mode 3: drive MOSI on the falling edge, sample MISO just before rising.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk  = 1'b0;
      spi_mosi = tx[i];
      tick(HALF);
      rx[i]   = spi_miso;
      spi_clk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic xchk(input logic [7:0] tx, input logic [7:0] exp, input string tag);
    logic [7:0] rx;
    xfer(tx, 8, rx);
    chk(tag, rx, exp);
  endtask

  task automatic cs_lo();
    spi_csn = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_hi();
    tick(HALF);
    spi_csn = 1'b1;
    tick(2 * HALF);
  endtask

  initial begin
    logic [7:0] rx;
    reset    = 1'b1;
    spi_clk  = 1'b1;
    spi_csn  = 1'b1;
    spi_mosi = 1'b1;
    tick(3);
    chk("rst_miso", spi_miso, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wel", wel, 1'b0);
    chk("rst_cmd_count", cmd_count, 8'd0);
    reset = 1'b0;
    tick(4);

    // RDID
    cs_lo();
    chk("busy_in_cs", busy, 1'b1);
    xchk(8'h9F, 8'hFF, "rdid_op");
    xchk(8'h00, 8'hEF, "rdid_b0");
    xchk(8'h00, 8'h40, "rdid_b1");
    xchk(8'h00, 8'h16, "rdid_b2");
    xchk(8'h00, 8'hFF, "rdid_fill");
    cs_hi();
    chk("rdid_cnt", cmd_count, 8'd1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_miso", spi_miso, 1'b1);

    // READ at 0x3E with wrap
    cs_lo();
    xchk(8'h03, 8'hFF, "rd_op");
    xchk(8'h00, 8'hFF, "rd_a2");
    xchk(8'h00, 8'hFF, "rd_a1");
    xchk(8'h3E, 8'hFF, "rd_a0");
    xchk(8'h00, 8'h9B, "rd_3e");
    xchk(8'h00, 8'h9A, "rd_3f");
    xchk(8'h00, 8'hA5, "rd_wrap_00");
    cs_hi();
    chk("rd_cnt", cmd_count, 8'd2);

    // WREN then status shows wel
    cs_lo();
    xchk(8'h06, 8'hFF, "wren_op");
    cs_hi();
    chk("wren_wel", wel, PROG);
    cs_lo();
    xchk(8'h05, 8'hFF, "rdsr1_op");
    xchk(8'h00, PROG ? 8'h02 : 8'h00, "rdsr1_val");
    cs_hi();

    // PROG AA 55 at 0x10
    cs_lo();
    xchk(8'h02, 8'hFF, "pg_op");
    xchk(8'h00, 8'hFF, "pg_a2");
    xchk(8'h00, 8'hFF, "pg_a1");
    xchk(8'h10, 8'hFF, "pg_a0");
    xchk(8'hAA, 8'hFF, "pg_d0");
    xchk(8'h55, 8'hFF, "pg_d1");
    cs_hi();
    chk("pg_wel_cleared", wel, 1'b0);
    chk("pg_cnt", cmd_count, 8'd5);

    cs_lo();
    xchk(8'h03, 8'hFF, "rb_op");
    xchk(8'h00, 8'hFF, "rb_a2");
    xchk(8'h00, 8'hFF, "rb_a1");
    xchk(8'h10, 8'hFF, "rb_a0");
    xchk(8'h00, PROG ? 8'hAA : 8'hB5, "rb_10");
    xchk(8'h00, PROG ? 8'h55 : 8'hB4, "rb_11");
    cs_hi();

    cs_lo();
    xchk(8'h05, 8'hFF, "rdsr2_op");
    xchk(8'h00, 8'h00, "rdsr2_val");
    cs_hi();

    // WREN then WRDI, then a PROG that must be discarded
    cs_lo();
    xchk(8'h06, 8'hFF, "wren2_op");
    cs_hi();
    chk("wren2_wel", wel, PROG);
    cs_lo();
    xchk(8'h04, 8'hFF, "wrdi_op");
    cs_hi();
    chk("wrdi_wel", wel, 1'b0);

    cs_lo();
    xchk(8'h02, 8'hFF, "pgx_op");
    xchk(8'h00, 8'hFF, "pgx_a2");
    xchk(8'h00, 8'hFF, "pgx_a1");
    xchk(8'h20, 8'hFF, "pgx_a0");
    xchk(8'h11, 8'hFF, "pgx_d0");
    cs_hi();
    chk("pgx_wel", wel, 1'b0);

    cs_lo();
    xchk(8'h03, 8'hFF, "rbx_op");
    xchk(8'h00, 8'hFF, "rbx_a2");
    xchk(8'h00, 8'hFF, "rbx_a1");
    xchk(8'h20, 8'hFF, "rbx_a0");
    xchk(8'h00, 8'h85, "rbx_20");
    cs_hi();
    chk("rbx_cnt", cmd_count, 8'd11);

    // CS raised after 5 opcode bits: no decode
    cs_lo();
    xfer(8'h9F, 5, rx);
    cs_hi();
    chk("partial_cnt", cmd_count, 8'd11);
    cs_lo();
    xchk(8'h05, 8'hFF, "rdsr3_op");
    xchk(8'h00, 8'h00, "rdsr3_val");
    cs_hi();
    chk("rdsr3_cnt", cmd_count, 8'd12);

    // Reset pulsed mid-read
    cs_lo();
    xchk(8'h03, 8'hFF, "rr_op");
    xchk(8'h00, 8'hFF, "rr_a2");
    xchk(8'h00, 8'hFF, "rr_a1");
    xchk(8'h00, 8'hFF, "rr_a0");
    xchk(8'h00, 8'hA5, "rr_00");
    xfer(8'h00, 3, rx);
    chk("rr_cnt_pre", cmd_count, 8'd13);
    reset = 1'b1;
    #2;
    chk("rr_miso", spi_miso, 1'b1);
    chk("rr_busy", busy, 1'b0);
    chk("rr_cnt", cmd_count, 8'd0);
    spi_csn = 1'b1;
    spi_clk = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2 * HALF);
    cs_lo();
    xchk(8'h9F, 8'hFF, "rid_op");
    xchk(8'h00, 8'hEF, "rid_b0");
    xchk(8'h00, 8'h40, "rid_b1");
    xchk(8'h00, 8'h16, "rid_b2");
    cs_hi();
    chk("rid_cnt", cmd_count, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
